my_pc_stack: RTL and testbench
==============================

Name: my_pc_stack

Overview:
- 16-bit Hack program counter with a small return-address stack. Sits directly upstream of the instruction ROM address port, beside the my_register-based A/D registers.
- Its output addresses the next instruction. Its load input comes from the A register.
- Adds call/return so later CPU extensions can branch to subroutines without software stack emulation.

Parameters:
- WIDTH, 16, address/data width of the counter and stack entries
- DEPTH, 8, number of return-address stack entries (power of two not required, must be >= 1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in  input  WIDTH  jump target (from A register)
- load  input  1  jump: out <= in
- push  input  1  with load: call (save return address, then jump)
- pop  input  1  return: out <= top of stack
- inc  input  1  advance: out <= out + 1
- clear  input  1  synchronous Hack-style reset: out <= 0
- out  output  WIDTH  current program counter
- empty  output  1  stack holds no entries
- full  output  1  stack holds DEPTH entries
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset:
  - rst_n low forces out=0, stack pointer sp=0, overflow=0 and underflow=0, regardless of clk. All stack entries are cleared to 0.
  - Outputs are therefore empty=1, full=0.
- empty and full are combinational from sp: empty = (sp==0), full = (sp==DEPTH). sp width is clog2(DEPTH+1).
- Each rising edge applies exactly one operation, in priority order:
  1. clear: out<=0, sp<=0, both sticky flags cleared. Stack contents are don't-care.
  2. load & push (call):
     - If not full: stack[sp]<=out+1 (mod 2^WIDTH), sp<=sp+1, out<=in.
     - If full: out<=in, no stack change, overflow<=1.
  3. load (without push): out<=in. Stack untouched.
  4. pop (return):
     - If not empty: out<=stack[sp-1], sp<=sp-1.
     - If empty: out holds, underflow<=1.
  5. inc: out<=out+1. Wraps 0xFFFF -> 0x0000 with no flag.
  6. none: out holds.
- push without load is ignored. No state change, no flag.
- Lower-priority inputs asserted together with a higher one are ignored; load+pop is a jump only.
- Latency: every update is visible on out immediately after the active edge (one-cycle register, same timing as my_register). No combinational path from any input to out.
- Sticky flags:
  - Once set, a flag holds until clear or rst_n.
  - While set, a flag does not block further operations.
- Asynchronous reset mid-operation: state goes to reset values at once. The first edge after rst_n deasserts applies normally.
- clear is fully synchronous. It has no effect between edges.

Test Plan:
- Reset then inc: rst_n=0 -> out=0, empty=1. Release and 3 edges with inc=1 -> out=3.
- Jump and wrap: load=1, in=0xFFFE -> out=0xFFFE. Two inc edges -> out=0xFFFF then 0x0000, no flags.
- Call/return:
  - At out=0x0010, load=1, push=1, in=0x0100 -> out=0x0100, empty=0.
  - Then 2 inc edges -> out=0x0102.
  - Then pop -> out=0x0011, empty=1.
- Overflow (DEPTH=8): 8 calls -> full=1. 9th call with in=0x0200 -> out=0x0200, overflow=1, sp stays 8. Then 8 pops return the 8 saved addresses in LIFO order.
- Underflow and priority:
  - pop on empty stack at out=5 -> out=5, underflow=1.
  - clear=1 with inc=1, load=1 -> out=0, underflow=0.
  - push alone -> no change.
- Async reset mid-stream: after 3 calls, drop rst_n between edges -> out=0, empty=1 before the next edge, flags 0.

Source files
------------

// File: rtl/my_pc_stack.sv
// my_pc_stack
// -----------------------------------------------------------------------------
// Hack program counter with a small return-address stack. The registered
// output addresses the instruction ROM; the jump target comes from the A
// register. Call saves the address after the current one and jumps; return
// restores the most recently saved address.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (out=0, stack emptied and zeroed,
//              sticky flags cleared)
//   in         jump target
//   load       jump: out <= in
//   push       together with load: call (save out+1, then jump)
//   pop        return: out <= top of stack
//   inc        advance: out <= out + 1 (wraps silently)
//   clear      synchronous Hack-style reset: out <= 0, stack emptied, flags off
//   out        current program counter (registered, no input-to-out path)
//   empty      stack holds no entries
//   full       stack holds DEPTH entries
//   overflow   sticky: a call was attempted while full
//   underflow  sticky: a return was attempted while empty
//
// One operation is applied per edge, highest priority first:
//   clear > call (load&push) > jump (load) > return (pop) > inc > hold.
// push without load is ignored; load+pop is a plain jump.
// The decoded operation is kept in op_t so that a checker can bind to it.
// -----------------------------------------------------------------------------
module my_pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             push,
    input  logic             pop,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    // Stack pointer must be able to hold the value DEPTH itself (full stack).
    localparam int SPW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_CALL  = 3'd2,
        OP_JUMP  = 3'd3,
        OP_RET   = 3'd4,
        OP_INC   = 3'd5
    } op_t;

    op_t              op;
    logic [SPW-1:0]   sp;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] ret_addr;

    // ------------------------------------------------------------------
    // Priority decode of the request lines into a single operation.
    // ------------------------------------------------------------------
    always_comb begin
        op = OP_NONE;
        if (clear) begin
            op = OP_CLEAR;
        end else if (load && push) begin
            op = OP_CALL;
        end else if (load) begin
            op = OP_JUMP;
        end else if (pop) begin
            op = OP_RET;
        end else if (inc) begin
            op = OP_INC;
        end
    end

    assign empty    = (sp == '0);
    assign full     = (sp == SPW'(DEPTH));
    assign ret_addr = out + WIDTH'(1);

    // Top-of-stack read: entry sp-1, selected by comparison so the index
    // never goes out of range when the stack is empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) begin
                top = stack[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Program counter, stack pointer and sticky flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_CLEAR: begin
                    out       <= '0;
                    sp        <= '0;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                OP_CALL: begin
                    // The jump happens even when the save is refused.
                    out <= in;
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        sp <= sp + SPW'(1);
                    end
                end
                OP_JUMP: begin
                    out <= in;
                end
                OP_RET: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        out <= top;
                        sp  <= sp - SPW'(1);
                    end
                end
                OP_INC: begin
                    out <= out + WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Return-address storage. Only a successful call writes; clear leaves
    // the old contents in place since they are unreachable once sp is 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (op == OP_CALL && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp == SPW'(i)) begin
                    stack[i] <= ret_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_pc_stack.sv
// Testbench for my_pc_stack: directed walk through the call/return, wrap,
// overflow/underflow and priority cases, then randomized traffic. Expected
// state comes from a queue-based reference model of the return stack.
module tb_my_pc_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int EW    = WIDTH + 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic             load;
    logic             push;
    logic             pop;
    logic             inc;
    logic             clear;
    logic [WIDTH-1:0] out;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    my_pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .load      (load),
        .push      (push),
        .pop       (pop),
        .inc       (inc),
        .clear     (clear),
        .out       (out),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stk[$];
    logic             m_ov;
    logic             m_un;

    function automatic logic [EW-1:0] model_state();
        return {m_pc, (m_stk.size() == 0), (m_stk.size() == DEPTH), m_ov, m_un};
    endfunction

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic l, input logic p,
                              input logic r, input logic i, input logic [WIDTH-1:0] d);
        if (c) begin
            model_reset();
        end else if (l && p) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
            else                      m_ov = 1'b1;
            m_pc = d;
        end else if (l) begin
            m_pc = d;
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_un = 1'b1;
        end else if (i) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    function automatic logic [EW-1:0] dut_state();
        return {out, empty, full, overflow, underflow};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%h e=%b f=%b ov=%b un=%b, expected out=%h e=%b f=%b ov=%b un=%b",
                     name, act[EW-1:4], act[3], act[2], act[1], act[0],
                     exp[EW-1:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic c, input logic l, input logic p,
                         input logic r, input logic i, input logic [WIDTH-1:0] d);
        @(negedge clk);
        clear = c; load = l; push = p; pop = r; inc = i; in = d;
        model_step(c, l, p, r, i, d);
        exp_q.push_back(model_state());
    endtask

    task automatic do_inc();                           drive(0, 0, 0, 0, 1, $urandom()); endtask
    task automatic do_jump(input logic [WIDTH-1:0] d); drive(0, 1, 0, 0, 0, d);          endtask
    task automatic do_call(input logic [WIDTH-1:0] d); drive(0, 1, 1, 0, 0, d);          endtask
    task automatic do_ret();                           drive(0, 0, 0, 1, 0, $urandom()); endtask
    task automatic do_idle();                          drive(0, 0, 0, 0, 0, $urandom()); endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("edge", dut_state(), e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [EW-1:0] exp_rst;
        rst_n = 1'b0;
        clear = 0; load = 0; push = 0; pop = 0; inc = 0; in = '0;
        model_reset();
        exp_rst = model_state();
        #1;
        check("reset", dut_state(), exp_rst);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then inc x3
        repeat (3) do_inc();
        // Jump and wrap
        do_jump(16'hFFFE);
        do_inc();
        do_inc();
        // Call/return
        do_jump(16'h0010);
        do_call(16'h0100);
        do_inc();
        do_inc();
        do_ret();
        // Overflow: 8 calls fill, 9th sets overflow, 8 pops LIFO, one more underflows
        for (int k = 0; k < DEPTH; k++) do_call(16'($urandom()));
        do_call(16'h0200);
        for (int k = 0; k < DEPTH; k++) do_ret();
        do_ret();
        // Underflow at out=5 after clear, then priority cases
        drive(1, 0, 0, 0, 0, 16'h0);
        do_jump(16'h0005);
        do_ret();
        drive(1, 1, 0, 0, 1, 16'h1234);
        drive(0, 0, 1, 0, 0, 16'h4321);   // push alone
        do_call(16'h0040);
        drive(0, 1, 0, 1, 0, 16'h0077);   // load+pop is a jump only
        do_ret();

        // Async reset mid-stream
        repeat (3) do_call(16'($urandom()));
        do_idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_state(), model_state());
        @(negedge clk);
        rst_n = 1'b1;
        do_inc();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 16'($urandom()));
        end
        do_idle();

        // Drain with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
